mem_access_stage: RTL and testbench

//  MEM pipeline stage: consumer of the EX/MEM register outputs. Runs load/store through a
//  req/ack data-memory port and stalls upstream until the memory acknowledges.

---
 rtl/mem_access_stage.sv | 137 +++++++++++++
 tb/tb_mem_access_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the req/ack data-memory port for loads/stores, stalls
// upstream while an access is outstanding, and owns the MEM/WB register.
module mem_access_stage #(
  parameter int WORD   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_w_in,
  input  logic              mem_r_in,
  input  logic              wb_en_in,
  input  logic [4:0]        reg_dest_in,
  input  logic [WORD-1:0]   alu_in,
  input  logic [WORD-1:0]   st_data_in,
  input  logic              terminate_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [WORD-1:0]   dmem_wdata,
  input  logic [WORD-1:0]   dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              fwd_valid,
  output logic [4:0]        fwd_reg,
  output logic [WORD-1:0]   fwd_data,
  output logic              wb_en_out,
  output logic [4:0]        reg_dest_out,
  output logic [WORD-1:0]   wb_data_out,
  output logic              terminate_out
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state = IDLE;
  state_t            state_nx;
  logic              req_q = 1'b0;
  logic              we_q = 1'b0;
  logic [ADDR_W-1:0] addr_q = '0;
  logic [WORD-1:0]   wdata_q = '0;
  logic              wb_en_q = 1'b0;
  logic [4:0]        reg_dest_q = '0;
  logic [WORD-1:0]   wb_data_q = '0;
  logic              term_q = 1'b0;

  logic            memop;
  logic            is_load;
  logic            issue;
  logic            done;
  logic            wb_en_nx;
  logic [4:0]      reg_dest_nx;
  logic [WORD-1:0] wb_data_nx;
  logic            term_nx;

  assign memop   = mem_r_in | mem_w_in;
  assign is_load = mem_r_in & ~mem_w_in;

  always_comb begin
    state_nx    = state;
    stall       = 1'b0;
    issue       = 1'b0;
    done        = 1'b0;
    wb_en_nx    = 1'b0;
    reg_dest_nx = '0;
    wb_data_nx  = '0;
    term_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (memop) begin
          stall    = 1'b1;
          issue    = 1'b1;
          state_nx = ACCESS;
        end else begin
          wb_en_nx    = wb_en_in;
          reg_dest_nx = reg_dest_in;
          wb_data_nx  = alu_in;
          term_nx     = terminate_in;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          done        = 1'b1;
          state_nx    = IDLE;
          wb_en_nx    = wb_en_in;
          reg_dest_nx = reg_dest_in;
          wb_data_nx  = is_load ? dmem_rdata : alu_in;
          term_nx     = terminate_in;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_en_q    <= 1'b0;
      reg_dest_q <= '0;
      wb_data_q  <= '0;
      term_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      wb_en_q    <= wb_en_nx;
      reg_dest_q <= reg_dest_nx;
      wb_data_q  <= wb_data_nx;
      term_q     <= term_nx;
      // Port fields are only written on issue so they stay stable through wait states.
      if (issue) begin
        req_q   <= 1'b1;
        we_q    <= mem_w_in;
        addr_q  <= alu_in[ADDR_W-1:0];
        wdata_q <= st_data_in;
      end else if (done) begin
        req_q <= 1'b0;
      end
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign wb_en_out     = wb_en_q;
  assign reg_dest_out  = reg_dest_q;
  assign wb_data_out   = wb_data_q;
  assign terminate_out = term_q;

  assign fwd_valid = wb_en_in & ~mem_r_in;
  assign fwd_reg   = reg_dest_in;
  assign fwd_data  = alu_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: reset, ALU pass-through, load with
// wait states, store, reset mid-access, back-to-back loads and forwarding.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_w_in = 1'b0;
  logic        mem_r_in = 1'b0;
  logic        wb_en_in = 1'b0;
  logic [4:0]  reg_dest_in = '0;
  logic [31:0] alu_in = '0;
  logic [31:0] st_data_in = '0;
  logic        terminate_in = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        stall;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        wb_en_out;
  logic [4:0]  reg_dest_out;
  logic [31:0] wb_data_out;
  logic        terminate_out;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.WORD(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_w_in(mem_w_in), .mem_r_in(mem_r_in), .wb_en_in(wb_en_in),
    .reg_dest_in(reg_dest_in), .alu_in(alu_in), .st_data_in(st_data_in),
    .terminate_in(terminate_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .wb_en_out(wb_en_out), .reg_dest_out(reg_dest_out), .wb_data_out(wb_data_out),
    .terminate_out(terminate_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    mem_w_in = 1'b0; mem_r_in = 1'b0; wb_en_in = 1'b0;
    reg_dest_in = '0; alu_in = '0; st_data_in = '0; terminate_in = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== '0) begin errors++;
      $display("FAIL t0_port got req=%b we=%b addr=%h wdata=%h want all 0", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
    checks++; if ({wb_en_out, reg_dest_out, wb_data_out, terminate_out} !== '0) begin errors++;
      $display("FAIL t0_memwb got %b %h %h %b want all 0", wb_en_out, reg_dest_out, wb_data_out, terminate_out); end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wb_en_in = 1'b1; terminate_in = 1'b1;
      reg_dest_in = 5'($urandom); alu_in = $urandom; st_data_in = $urandom;
      dmem_rdata = $urandom; dmem_ack = 1'($urandom);
      tick();
      checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== '0) begin errors++;
        $display("FAIL rst_port got req=%b we=%b addr=%h wdata=%h want all 0", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
      checks++; if ({wb_en_out, reg_dest_out, wb_data_out, terminate_out} !== '0) begin errors++;
        $display("FAIL rst_memwb got %b %h %h %b want all 0", wb_en_out, reg_dest_out, wb_data_out, terminate_out); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall); end
    end
    rst = 1'b0; dmem_ack = 1'b0; drive_nop();
    tick();
  endtask

  task automatic test_alu();
    wb_en_in = 1'b1; reg_dest_in = 5'd5; alu_in = 32'h1234; terminate_in = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %b want 0", stall); end
    tick();
    checks++; if ({wb_en_out, reg_dest_out, wb_data_out} !== {1'b1, 5'd5, 32'h1234}) begin errors++;
      $display("FAIL alu_wb got en=%b dest=%0d data=%h want en=1 dest=5 data=00001234", wb_en_out, reg_dest_out, wb_data_out); end
    checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin errors++;
      $display("FAIL alu_nostall got stall=%b req=%b want 0 0", stall, dmem_req); end
    terminate_in = 1'b1; wb_en_in = 1'b0;
    tick();
    checks++; if (terminate_out !== 1'b1 || wb_en_out !== 1'b0) begin errors++;
      $display("FAIL alu_term got term=%b en=%b want 1 0", terminate_out, wb_en_out); end
    drive_nop();
    tick();
  endtask

  task automatic test_load_wait();
    int stall_cnt = 0;
    mem_r_in = 1'b1; wb_en_in = 1'b1; reg_dest_in = 5'd7; alu_in = 32'h40;
    #1;
    if (stall) stall_cnt++;
    // ack arrives in the fourth ACCESS cycle, three cycles after req rises
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 32'h40}) begin errors++;
        $display("FAIL ld_port c%0d got req=%b we=%b addr=%h want 1 0 00000040", c, dmem_req, dmem_we, dmem_addr); end
      checks++; if (wb_en_out !== 1'b0) begin errors++; $display("FAIL ld_bubble c%0d got en=%b want 0", c, wb_en_out); end
      if (c == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF; end
      #1;
      if (stall) stall_cnt++;
    end
    checks++; if (stall_cnt != 4) begin errors++; $display("FAIL ld_stall_cycles got %0d want 4", stall_cnt); end
    tick();
    dmem_ack = 1'b0; dmem_rdata = '0;
    checks++; if ({wb_en_out, reg_dest_out, wb_data_out} !== {1'b1, 5'd7, 32'hDEADBEEF}) begin errors++;
      $display("FAIL ld_wb got en=%b dest=%0d data=%h want en=1 dest=7 data=deadbeef", wb_en_out, reg_dest_out, wb_data_out); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL ld_req_drop got %b want 0", dmem_req); end
    drive_nop();
    tick();
  endtask

  task automatic test_store();
    mem_w_in = 1'b1; alu_in = 32'h80; st_data_in = 32'hCAFE; reg_dest_in = 5'd9;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL st_stall_idle got %b want 1", stall); end
    tick();
    checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 32'h80, 32'hCAFE}) begin errors++;
      $display("FAIL st_port got req=%b we=%b addr=%h wdata=%h want 1 1 00000080 0000cafe", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL st_stall_ack got %b want 0", stall); end
    tick();
    dmem_ack = 1'b0;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL st_one_req got req=%b want 0", dmem_req); end
    checks++; if (wb_en_out !== 1'b0 || wb_data_out !== 32'h80) begin errors++;
      $display("FAIL st_wb got en=%b data=%h want en=0 data=00000080", wb_en_out, wb_data_out); end
    drive_nop();
    tick();
  endtask

  task automatic test_reset_mid_access();
    mem_r_in = 1'b1; wb_en_in = 1'b1; reg_dest_in = 5'd3; alu_in = 32'h100;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rstacc_req got %b want 0", dmem_req); end
    rst = 1'b0; drive_nop();
    dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstacc_stall got %b want 0", stall); end
    tick();
    dmem_ack = 1'b0;
    checks++; if ({dmem_req, wb_en_out, reg_dest_out, wb_data_out} !== '0) begin errors++;
      $display("FAIL rstacc_memwb got req=%b en=%b dest=%0d data=%h want all 0", dmem_req, wb_en_out, reg_dest_out, wb_data_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    mem_r_in = 1'b1; wb_en_in = 1'b1; reg_dest_in = 5'd1; alu_in = 32'h10;
    tick();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL b2b_req1 got %b want 1", dmem_req); end
    dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
    tick();
    dmem_ack = 1'b0;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b want 0", dmem_req); end
    checks++; if ({wb_en_out, reg_dest_out, wb_data_out} !== {1'b1, 5'd1, 32'h11111111}) begin errors++;
      $display("FAIL b2b_wb1 got en=%b dest=%0d data=%h want 1 1 11111111", wb_en_out, reg_dest_out, wb_data_out); end
    reg_dest_in = 5'd2; alu_in = 32'h20;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall2 got %b want 1", stall); end
    tick();
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h20) begin errors++;
      $display("FAIL b2b_req2 got req=%b addr=%h want 1 00000020", dmem_req, dmem_addr); end
    dmem_ack = 1'b1; dmem_rdata = 32'h22222222;
    tick();
    checks++; if ({wb_en_out, reg_dest_out, wb_data_out} !== {1'b1, 5'd2, 32'h22222222}) begin errors++;
      $display("FAIL b2b_wb2 got en=%b dest=%0d data=%h want 1 2 22222222", wb_en_out, reg_dest_out, wb_data_out); end
    drive_nop();
    dmem_rdata = 32'h33333333;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stray_stall got %b want 0", stall); end
    tick();
    dmem_ack = 1'b0;
    checks++; if ({dmem_req, wb_en_out, wb_data_out} !== '0) begin errors++;
      $display("FAIL b2b_stray got req=%b en=%b data=%h want all 0", dmem_req, wb_en_out, wb_data_out); end
  endtask

  task automatic test_forward();
    wb_en_in = 1'b1; reg_dest_in = 5'd9; alu_in = 32'h55;
    #1;
    checks++; if ({fwd_valid, fwd_reg, fwd_data} !== {1'b1, 5'd9, 32'h55}) begin errors++;
      $display("FAIL fwd_alu got v=%b reg=%0d data=%h want 1 9 00000055", fwd_valid, fwd_reg, fwd_data); end
    mem_r_in = 1'b1;
    #1;
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL fwd_load got %b want 0", fwd_valid); end
    drive_nop();
    #1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_reset_mid_access();
    test_back_to_back();
    test_forward();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
